bp_mem_sram_slave: RTL and testbench

BP_MEM_SRAM_SLAVE -- requirements
Module: bp_mem_sram_slave

---
 rtl/bp_mem_sram_slave_pkg.sv | 39 +++
 rtl/bsg_mem_1rw_sync_mask_write_byte.sv | 20 ++
 rtl/bp_mem_sram_slave.sv | 86 ++++++++
 tb/tb_bp_mem_sram_slave.sv | 136 +++++++++++++
 4 files changed

// File: rtl/bp_mem_sram_slave_pkg.sv
// bp_mem_sram_slave_pkg: bp_common configuration, memory message types and structs
package bp_mem_sram_slave_pkg;
  typedef enum logic {e_bp_inv_cfg, e_bp_unicore_cfg} bp_params_e;
  localparam int paddr_width_p = 40;
  localparam int cce_block_width_p = 512;
  localparam int lce_id_width_p = 4;
  localparam int lce_assoc_p = 8;
  localparam int block_width_lut [2] = '{cce_block_width_p, cce_block_width_p};
  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'b0000,
    e_cce_mem_wr    = 4'b0001,
    e_cce_mem_uc_rd = 4'b0010,
    e_cce_mem_uc_wr = 4'b0011,
    e_cce_mem_pre   = 4'b0100
  } bp_cce_mem_cmd_type_e;
  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_cce_mem_msg_size_e;
  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [$clog2(lce_assoc_p)-1:0] way_id;
  } bp_cce_mem_msg_payload_s;
  typedef struct packed {
    bp_cce_mem_msg_payload_s payload;
    bp_cce_mem_msg_size_e size;
    logic [paddr_width_p-1:0] addr;
    bp_cce_mem_cmd_type_e msg_type;
  } bp_cce_mem_msg_header_s;
  typedef struct packed {
    bp_cce_mem_msg_header_s header;
    logic [cce_block_width_p-1:0] data;
  } bp_cce_mem_msg_s;
endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port synchronous RAM with byte write mask
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int data_width_p = 64,
  parameter int els_p = 8192
) (
  input  logic clk_i,
  input  logic v_i,
  input  logic w_i,
  input  logic [$clog2(els_p)-1:0] addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [data_width_p/8-1:0] write_mask_i,
  output logic [data_width_p-1:0] data_o
);
  logic [data_width_p-1:0] mem [els_p];
  always_ff @(posedge clk_i) begin
    if (v_i & ~w_i) data_o <= mem[addr_i];
    for (int i = 0; i < data_width_p/8; i++)
      if (v_i & w_i & write_mask_i[i]) mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
  end
endmodule

// File: rtl/bp_mem_sram_slave.sv
// bp_mem_sram_slave: SRAM-backed CCE memory slave with critical-word-first block accesses
module bp_mem_sram_slave
  import bp_mem_sram_slave_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int mem_els_p = 8192,
  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic mem_cmd_v_i,
  output logic mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic mem_resp_v_o,
  input  logic mem_resp_yumi_i
);
  localparam int beats_lp = block_width_lut[bp_params_p] / 64;
  localparam int cnt_w = $clog2(beats_lp + 1);
  localparam int lane_w = $clog2(beats_lp);
  localparam int idx_w = $clog2(mem_els_p);
  typedef enum logic [1:0] {e_idle, e_read, e_write, e_resp} state_e;
  state_e state_r, state_n;
  bp_cce_mem_msg_s cmd;
  bp_cce_mem_msg_header_s hdr_r;
  logic [cce_block_width_p-1:0] data_r;
  logic [cnt_w-1:0] cnt_r, beats;
  logic [2:0] sz, lg, sh;
  logic [7:0] bmask8, wmask;
  logic [idx_w-1:0] base, wrap, idx;
  logic [lane_w-1:0] lane;
  logic [63:0] ram_q, rdata, rmask, wdata;
  logic ram_v, cmd_rd, cmd_wr, resp_wr, accept;
  assign cmd = mem_cmd_i;
  assign cmd_rd = cmd.header.msg_type inside {e_cce_mem_rd, e_cce_mem_uc_rd};
  assign cmd_wr = cmd.header.msg_type inside {e_cce_mem_wr, e_cce_mem_uc_wr};
  assign resp_wr = hdr_r.msg_type inside {e_cce_mem_wr, e_cce_mem_uc_wr};
  assign mem_resp_o = {hdr_r, resp_wr ? cce_block_width_p'(0) : data_r};
  always_comb begin
    sz = hdr_r.size;
    lg = sz > 3'd6 ? 3'd3 : sz > 3'd3 ? sz - 3'd3 : 3'd0;
    beats = cnt_w'(1) << lg;
    wrap = (idx_w'(1) << lg) - idx_w'(1);
    base = hdr_r.addr[3 +: idx_w];
    idx = (base & ~wrap) | ((base + idx_w'(cnt_r)) & wrap);
    sh = sz < 3'd3 ? hdr_r.addr[2:0] : 3'd0;
    bmask8 = sz == 3'd0 ? 8'h01 : sz == 3'd1 ? 8'h03 : sz == 3'd2 ? 8'h0f : 8'hff;
    lane = state_r == e_read ? lane_w'(cnt_r - 1'b1) : lane_w'(cnt_r);
    wdata = data_r[64*lane +: 64] << {sh, 3'b000};
    wmask = bmask8 << sh;
    rmask = '0;
    for (int i = 0; i < 8; i++) rmask[8*i +: 8] = {8{bmask8[i]}};
    rdata = (ram_q >> {sh, 3'b000}) & rmask;
    ram_v = ~reset_i & ((state_r == e_read && cnt_r < beats) || state_r == e_write);
  end
  always_comb begin
    mem_cmd_ready_o = ~reset_i & (state_r == e_idle);
    mem_resp_v_o = ~reset_i & (state_r == e_resp);
    accept = mem_cmd_ready_o & mem_cmd_v_i;
    state_n = accept ? (cmd_rd ? e_read : cmd_wr ? e_write : e_resp)
      : (state_r == e_read && cnt_r == beats) ? e_resp
      : (state_r == e_write && cnt_r == beats - 1'b1) ? e_resp
      : (mem_resp_v_o && mem_resp_yumi_i) ? e_idle
      : state_r;
  end
  always_ff @(posedge clk_i) state_r <= reset_i ? e_idle : state_n;
  always_ff @(posedge clk_i)
    if (reset_i) cnt_r <= '0;
    else if (accept) begin
      cnt_r <= '0;
      hdr_r <= cmd.header;
      data_r <= cmd_wr ? cmd.data : '0;
    end else if (state_r == e_read || state_r == e_write) begin
      cnt_r <= cnt_r + 1'b1;
      if (state_r == e_read && cnt_r != '0) data_r[64*lane +: 64] <= rdata;
    end
  bsg_mem_1rw_sync_mask_write_byte #(.data_width_p(64), .els_p(mem_els_p)) ram (
    .clk_i,
    .v_i(ram_v),
    .w_i(state_r == e_write),
    .addr_i(idx),
    .data_i(wdata),
    .write_mask_i(wmask),
    .data_o(ram_q)
  );
endmodule

// File: tb/tb_bp_mem_sram_slave.sv
// tb_bp_mem_sram_slave: directed self-checking bench for bp_mem_sram_slave
module tb_bp_mem_sram_slave;
  import bp_mem_sram_slave_pkg::*;
  localparam int W = $bits(bp_cce_mem_msg_s);
  logic clk_i = 1'b0;
  logic reset_i, mem_cmd_v_i, mem_cmd_ready_o, mem_resp_v_o, mem_resp_yumi_i;
  logic [W-1:0] mem_cmd_i, mem_resp_o;
  bp_cce_mem_msg_s resp;
  int checks = 0;
  int errors = 0;
  assign resp = mem_resp_o;
  always #5 clk_i = ~clk_i;
  bp_mem_sram_slave dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .mem_cmd_i(mem_cmd_i),
    .mem_cmd_v_i(mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_resp_o(mem_resp_o),
    .mem_resp_v_o(mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i)
  );
  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                         input bp_cce_mem_msg_size_e s, input logic [511:0] d);
    bp_cce_mem_msg_s m;
    m = '0;
    m.header.msg_type = t;
    m.header.addr = a;
    m.header.size = s;
    m.data = d;
    return m;
  endfunction
  task automatic send(input bp_cce_mem_msg_s m, output int lat);
    int n;
    n = 0;
    while (!mem_cmd_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
    check("cmd_ready", mem_cmd_ready_o, 1);
    mem_cmd_i = m;
    mem_cmd_v_i = 1'b1;
    @(posedge clk_i); #1;
    mem_cmd_v_i = 1'b0;
    mem_cmd_i = '0;
    lat = 0;
    while (!mem_resp_v_o && lat < 50) begin @(posedge clk_i); #1; lat++; end
  endtask
  task automatic consume();
    mem_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    mem_resp_yumi_i = 1'b0;
  endtask
  task automatic xact(input string tag, input bp_cce_mem_msg_s m, input int exp_lat, input logic [511:0] exp_data);
    int lat;
    send(m, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_hdr"}, resp.header, m.header);
    check({tag, "_data"}, resp.data, exp_data);
    consume();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bp_cce_mem_msg_s m;
    logic [W-1:0] snap;
    int lat;
    reset_i = 1'b1;
    mem_cmd_v_i = 1'b0;
    mem_resp_yumi_i = 1'b0;
    mem_cmd_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ready", mem_cmd_ready_o, 0);
    check("reset_resp_v", mem_resp_v_o, 0);
    reset_i = 1'b0;
    #1;
    check("post_reset_ready", mem_cmd_ready_o, 1);
    xact("uc_wr8", mk(e_cce_mem_uc_wr, 40'h80_0000_0010, e_mem_size_8, 512'h1122334455667788), 1, '0);
    xact("uc_rd8", mk(e_cce_mem_uc_rd, 40'h80_0000_0010, e_mem_size_8, '0), 2, 512'h1122334455667788);
    xact("blk_wr", mk(e_cce_mem_wr, 40'h80_0000_0040, e_mem_size_64,
         {64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1, 64'd0}), 8, '0);
    xact("blk_rd", mk(e_cce_mem_rd, 40'h80_0000_0058, e_mem_size_64, '0), 9,
         {64'd2, 64'd1, 64'd0, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3});
    xact("zero_wr8", mk(e_cce_mem_uc_wr, 40'h80_0000_0010, e_mem_size_8, '0), 1, '0);
    xact("uc_wr1", mk(e_cce_mem_uc_wr, 40'h80_0000_0013, e_mem_size_1, 512'hAB), 1, '0);
    xact("uc_rd8_byte", mk(e_cce_mem_uc_rd, 40'h80_0000_0010, e_mem_size_8, '0), 2, 512'h00000000AB000000);
    xact("uc_rd1", mk(e_cce_mem_uc_rd, 40'h80_0000_0013, e_mem_size_1, '0), 2, 512'hAB);
    xact("other_type", mk(e_cce_mem_pre, 40'h80_0000_0040, e_mem_size_64, {512{1'b1}}), 0, '0);
    send(mk(e_cce_mem_uc_rd, 40'h80_0000_0010, e_mem_size_8, '0), lat);
    check("hold_lat", lat, 2);
    check("hold_data", resp.data, 512'h00000000AB000000);
    snap = mem_resp_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("hold_stable", mem_resp_o, snap);
      check("hold_ready", mem_cmd_ready_o, 0);
      check("hold_v", mem_resp_v_o, 1);
    end
    consume();
    check("hold_consumed_v", mem_resp_v_o, 0);
    check("hold_consumed_ready", mem_cmd_ready_o, 1);
    mem_cmd_i = mk(e_cce_mem_rd, 40'h80_0000_0040, e_mem_size_64, '0);
    mem_cmd_v_i = 1'b1;
    @(posedge clk_i); #1;
    mem_cmd_v_i = 1'b0;
    mem_cmd_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check("midrst_ready", mem_cmd_ready_o, 0);
    check("midrst_resp_v", mem_resp_v_o, 0);
    reset_i = 1'b0;
    #1;
    check("midrst_ready_after", mem_cmd_ready_o, 1);
    repeat (12) @(posedge clk_i);
    #1;
    check("midrst_no_resp", mem_resp_v_o, 0);
    xact("blk_rd_after_rst", mk(e_cce_mem_rd, 40'h80_0000_0058, e_mem_size_64, '0), 9,
         {64'd2, 64'd1, 64'd0, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3});
    m = mk(e_cce_mem_uc_rd, 40'h80_0000_0048, e_mem_size_8, '0);
    m.header.payload.lce_id = 4'd1;
    m.header.payload.way_id = 3'($urandom);
    xact("payload", m, 2, 512'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
